prog_loader: RTL and testbench

- Writer-side counterpart to the CPU result readout: streams a program image into instruction memory before the CPU starts.
- Accepts a byte stream under valid/ready and assembles bytes into instruction words.
- Writes each word to sequential instruction-memory addresses and verifies an additive checksum.
- Holds the CPU in reset until the load succeeds, then releases it.

---
 rtl/prog_loader.sv | 145 ++++++++++++++
 tb/tb_prog_loader.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_loader.sv
// prog_loader: streams a program image into instruction memory ahead of CPU start.
//
// The stream is a word count N, then N words sent most-significant byte first,
// then an 8-bit additive checksum of the payload bytes. Each assembled word is
// written to sequential addresses starting at 0. The CPU is held in reset until
// the checksum matches.
//
// State table
//   state  | meaning
//   S_LEN  | waiting for the word-count byte
//   S_DATA | collecting payload bytes, writing one word per INSTR_W/8 bytes
//   S_CHK  | waiting for the checksum byte
//   S_RUN  | load good, CPU released (terminal)
//   S_FAIL | oversize count or bad checksum, CPU held (terminal until reset)
//
// Ports
//   clk, reset           clock, asynchronous active-high reset
//   in_valid/in_data     byte stream source
//   in_ready             loader can accept a byte (decoded from state only)
//   mem_we/mem_addr/
//   mem_wr_data          one-cycle instruction-memory write
//   cpu_reset            CPU core reset, low only in S_RUN
//   done / error         load passed / load failed
module prog_loader #(
   parameter int INSTR_W = 16,
   parameter int ADDR_W  = 5
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               in_valid,
   input  logic [7:0]         in_data,
   output logic               in_ready,
   output logic               mem_we,
   output logic [ADDR_W-1:0]  mem_addr,
   output logic [INSTR_W-1:0] mem_wr_data,
   output logic               cpu_reset,
   output logic               done,
   output logic               error
);

   localparam int          BYTES     = INSTR_W / 8;
   localparam logic [2:0]  LAST_BYTE = 3'(BYTES - 1);
   localparam logic [31:0] CAP       = 32'd1 << ADDR_W;

   typedef enum logic [2:0] {S_LEN, S_DATA, S_CHK, S_RUN, S_FAIL} state_t;

   state_t             state, state_nxt;
   logic               accept;
   logic               word_done;
   logic [7:0]         n_words;
   logic [7:0]         sum;
   logic [2:0]         byte_cnt;
   logic [8:0]         word_idx;
   logic [INSTR_W-1:0] word_reg;
   logic [INSTR_W-1:0] word_nxt;

   assign accept    = in_valid & in_ready;
   // Concatenate then truncate so INSTR_W=8 needs no special case.
   assign word_nxt  = INSTR_W'({word_reg, in_data});
   assign word_done = (state == S_DATA) && accept && (byte_cnt == LAST_BYTE);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= S_LEN;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_LEN: begin
            if (accept) begin
               if ({24'd0, in_data} > CAP) state_nxt = S_FAIL;
               else if (in_data == 8'd0)   state_nxt = S_CHK;
               else                        state_nxt = S_DATA;
            end
         end
         S_DATA: begin
            if (word_done && ((word_idx + 9'd1) == {1'b0, n_words})) state_nxt = S_CHK;
         end
         S_CHK: begin
            if (accept) state_nxt = (in_data == sum) ? S_RUN : S_FAIL;
         end
         default: state_nxt = state;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         n_words     <= '0;
         sum         <= '0;
         byte_cnt    <= '0;
         word_idx    <= '0;
         word_reg    <= '0;
         mem_we      <= 1'b0;
         mem_addr    <= '0;
         mem_wr_data <= '0;
      end else begin
         mem_we <= 1'b0;
         case (state)
            S_LEN: begin
               if (accept) begin
                  n_words  <= in_data;
                  sum      <= '0;
                  byte_cnt <= '0;
                  word_idx <= '0;
                  word_reg <= '0;
               end
            end
            S_DATA: begin
               if (accept) begin
                  sum      <= sum + in_data;
                  word_reg <= word_nxt;
                  if (byte_cnt == LAST_BYTE) begin
                     byte_cnt    <= '0;
                     mem_we      <= 1'b1;
                     mem_addr    <= ADDR_W'(word_idx);
                     mem_wr_data <= word_nxt;
                     word_idx    <= word_idx + 9'd1;
                  end else begin
                     byte_cnt <= byte_cnt + 3'd1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   // Status outputs are registered from the next state so they change on the
   // same edge as the state they describe.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         in_ready  <= 1'b1;
         cpu_reset <= 1'b1;
         done      <= 1'b0;
         error     <= 1'b0;
      end else begin
         in_ready  <= (state_nxt == S_LEN) || (state_nxt == S_DATA) || (state_nxt == S_CHK);
         cpu_reset <= (state_nxt != S_RUN);
         done      <= (state_nxt == S_RUN);
         error     <= (state_nxt == S_FAIL);
      end
   end

endmodule

// File: tb/tb_prog_loader.sv
module tb_prog_loader;

   typedef logic [7:0] bq_t [$];
   typedef struct {
      logic [4:0]  a;
      logic [15:0] d;
   } wr_t;

   logic        clk;
   logic        reset;
   logic        in_valid;
   logic [7:0]  in_data;
   logic        in_ready;
   logic        mem_we;
   logic [4:0]  mem_addr;
   logic [15:0] mem_wr_data;
   logic        cpu_reset;
   logic        done;
   logic        error;

   int  checks;
   int  failures;
   wr_t exp_q[$];
   bit  all_done;

   prog_loader #(.INSTR_W(16), .ADDR_W(5)) dut (
      .clk         (clk),
      .reset       (reset),
      .in_valid    (in_valid),
      .in_data     (in_data),
      .in_ready    (in_ready),
      .mem_we      (mem_we),
      .mem_addr    (mem_addr),
      .mem_wr_data (mem_wr_data),
      .cpu_reset   (cpu_reset),
      .done        (done),
      .error       (error)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   // Reference model: derive expected writes and verdict from the stream itself.
   task automatic model(input bq_t s, output bit pass, output int n);
      int sum;
      n = int'(s[0]);
      pass = 1'b0;
      if (n > 32) return;
      sum = 0;
      for (int w = 0; w < n; w++) begin
         wr_t e;
         e.a = 5'(w);
         e.d = {s[1 + 2*w], s[2 + 2*w]};
         exp_q.push_back(e);
         sum = sum + int'(s[1 + 2*w]) + int'(s[2 + 2*w]);
      end
      pass = (int'(s[1 + 2*n]) == (sum % 256));
   endtask

   task automatic tick_neg(inout bit pend);
      @(negedge clk);
      if (pend) begin
         chk("we_latency", {31'd0, mem_we}, 32'd1);
         pend = 1'b0;
      end
   endtask

   task automatic drive(input bq_t s, input int gap_mode, input int n);
      bit pend;
      pend = 1'b0;
      for (int i = 0; i < s.size(); i++) begin
         int g;
         g = (gap_mode < 0) ? int'($urandom_range(0, 3)) : gap_mode;
         if (i == 0) g = 0;
         repeat (g) begin
            tick_neg(pend);
            in_valid = 1'b0;
         end
         tick_neg(pend);
         in_valid = 1'b1;
         in_data  = s[i];
         if (!in_ready) begin
            repeat (3) tick_neg(pend);
            break;
         end
         @(posedge clk);
         if (n <= 32 && i >= 2 && i <= 2*n && (i % 2) == 0) pend = 1'b1;
      end
      tick_neg(pend);
      in_valid = 1'b0;
   endtask

   task automatic do_reset();
      reset    = 1'b1;
      in_valid = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic run_load(input string tag, input bq_t s, input int gap_mode);
      bit pass;
      int n;
      do_reset();
      model(s, pass, n);
      drive(s, gap_mode, n);
      repeat (3) @(negedge clk);
      chk({tag, "_done"},      {31'd0, done},      {31'd0, pass});
      chk({tag, "_error"},     {31'd0, error},     {31'd0, !pass});
      chk({tag, "_cpu_reset"}, {31'd0, cpu_reset}, {31'd0, !pass});
      chk({tag, "_in_ready"},  {31'd0, in_ready},  32'd0);
      chk({tag, "_writes_left"}, exp_q.size(), 32'd0);
      exp_q.delete();
   endtask

   task automatic monitor();
      forever begin
         @(negedge clk);
         if (all_done) break;
         if (!reset) begin
            if (done && error) chk("done_error_excl", 32'd1, 32'd0);
            if (mem_we) begin
               if (exp_q.size() == 0) begin
                  chk("unexpected_write", {27'd0, mem_addr}, 32'hFFFF_FFFF);
               end else begin
                  wr_t e;
                  e = exp_q.pop_front();
                  chk("wr_addr", {27'd0, mem_addr}, {27'd0, e.a});
                  chk("wr_data", {16'd0, mem_wr_data}, {16'd0, e.d});
               end
            end
         end
      end
   endtask

   function automatic bq_t rand_stream();
      bq_t s;
      int  n;
      int  sum;
      n = int'($urandom_range(0, 34));
      s.push_back(8'(n));
      if (n > 32) begin
         repeat (3) s.push_back(8'($urandom));
         return s;
      end
      sum = 0;
      for (int k = 0; k < 2*n; k++) begin
         logic [7:0] b;
         b = 8'($urandom);
         s.push_back(b);
         sum = sum + int'(b);
      end
      if ($urandom_range(0, 2) == 0) s.push_back(8'(sum + 1 + int'($urandom_range(0, 254))));
      else                           s.push_back(8'(sum));
      return s;
   endfunction

   task automatic main();
      bq_t s;
      // reset state
      reset    = 1'b1;
      in_valid = 1'b0;
      in_data  = 8'h00;
      #1;
      chk("rst_in_ready",  {31'd0, in_ready},  32'd1);
      chk("rst_mem_we",    {31'd0, mem_we},    32'd0);
      chk("rst_mem_addr",  {27'd0, mem_addr},  32'd0);
      chk("rst_wr_data",   {16'd0, mem_wr_data}, 32'd0);
      chk("rst_cpu_reset", {31'd0, cpu_reset}, 32'd1);
      chk("rst_done",      {31'd0, done},      32'd0);
      chk("rst_error",     {31'd0, error},     32'd0);

      s = '{8'h03, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'h6A};
      run_load("basic", s, 0);
      s = '{8'h03, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'h09};
      run_load("badsum", s, 0);
      s = '{8'h03, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'h08};
      run_load("badsum08", s, 0);
      s = '{8'h03, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'h6A};
      run_load("gapped", s, 2);
      s = '{8'h00, 8'h00};
      run_load("n0", s, 0);
      s = '{8'h21, 8'h11, 8'h22, 8'h33};
      run_load("n33", s, 0);
      s = '{};
      s.push_back(8'h20);
      repeat (64) s.push_back(8'hFF);
      s.push_back(8'hC0);
      run_load("n32", s, 0);
      s = '{8'h02, 8'h80, 8'h00, 8'h80, 8'h01, 8'h01};
      run_load("wrap", s, 0);

      // reset mid-load, after the second payload byte
      do_reset();
      s = '{8'h03, 8'h12, 8'h34};
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         in_valid = 1'b1;
         in_data  = s[i];
         @(posedge clk);
      end
      #1;
      reset    = 1'b1;
      in_valid = 1'b0;
      #1;
      chk("mid_cpu_reset", {31'd0, cpu_reset}, 32'd1);
      chk("mid_mem_we",    {31'd0, mem_we},    32'd0);
      chk("mid_in_ready",  {31'd0, in_ready},  32'd1);
      chk("mid_mem_addr",  {27'd0, mem_addr},  32'd0);
      s = '{8'h03, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'h6A};
      run_load("rerun", s, 0);

      for (int r = 0; r < 20; r++) begin
         s = rand_stream();
         run_load("rand", s, -1);
      end

      all_done = 1'b1;
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      all_done = 1'b0;
      fork
         monitor();
         main();
      join
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
